// File: rtl/ps2_key_decoder_pkg.sv
// Shared scan-code constants, key indices and parser encodings
// for the PS/2 key decoder.
package ps2_key_decoder_pkg;

  localparam logic [7:0] SC_BRK = 8'hF0;
  localparam logic [7:0] SC_EXT = 8'hE0;
  localparam logic [7:0] SC_Q   = 8'h15;
  localparam logic [7:0] SC_Y   = 8'h35;
  localparam logic [7:0] SC_B   = 8'h32;
  localparam logic [7:0] SC_K   = 8'h42;

  localparam logic [1:0] KEY_Q = 2'd0;
  localparam logic [1:0] KEY_Y = 2'd1;
  localparam logic [1:0] KEY_B = 2'd2;
  localparam logic [1:0] KEY_K = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_BRK,
    ST_EXT,
    ST_EXT_BRK
  } ps2_state_t;

  typedef struct packed {
    logic       hit;
    logic [1:0] idx;
  } key_map_t;

  typedef struct packed {
    logic       make;
    logic [1:0] idx;
  } evt_t;

  function automatic key_map_t key_lookup(
    input logic [7:0] code
  );
    key_map_t m;
    m.hit = 1'b1;
    m.idx = KEY_Q;
    unique case (1'b1)
      code == SC_Q: m.idx = KEY_Q;
      code == SC_Y: m.idx = KEY_Y;
      code == SC_B: m.idx = KEY_B;
      code == SC_K: m.idx = KEY_K;
      default:      m.hit = 1'b0;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/ps2_key_decoder_if.sv
// Key-event stream: valid/ready handshake carrying a
// {make, key index} event code.
interface ps2_key_decoder_if;
  logic       evt_valid;
  logic       evt_ready;
  logic [2:0] evt_code;

  modport master (
    output evt_valid,
    output evt_code,
    input  evt_ready
  );

  modport slave (
    input  evt_valid,
    input  evt_code,
    output evt_ready
  );
endinterface

// File: rtl/ps2_evt_fifo.sv
// Small register FIFO: push/full write side, valid/ready read
// side, no empty-bypass so a push is visible the next cycle.
module ps2_evt_fifo #(
  parameter int WIDTH = 3,
  parameter int DEPTH = 4
) (
  input  logic             inclock,
  input  logic             resetn,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  output logic             full,
  output logic             valid,
  input  logic             ready,
  output logic [WIDTH-1:0] data
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count;
  logic             pop;
  logic             do_push;

  assign valid   = count != '0;
  assign full    = count == (AW+1)'(DEPTH);
  assign pop     = valid && ready;
  assign do_push = push && (!full || pop);
  assign data    = valid ? mem[rd_ptr] : '0;

  always_ff @(posedge inclock or negedge resetn) begin
    if (!resetn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      unique case ({do_push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/ps2_key_decoder.sv
// PS/2 scan-code parser: tracks held state of four keys and
// queues filtered make/break events.
module ps2_key_decoder
  import ps2_key_decoder_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 2_500_000,
  parameter int FIFO_DEPTH     = 4
) (
  input  logic               inclock,
  input  logic               resetn,
  input  logic [7:0]         ps2_key_data,
  input  logic               ps2_key_pressed,
  output logic [3:0]         key_held,
  ps2_key_decoder_if.master  evt,
  output logic               evt_overflow
);

  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  ps2_state_t    state;
  logic [TW-1:0] tmo;
  key_map_t      km;
  evt_t          ev;
  logic          ev_hit;
  logic          ev_acc;
  logic          fifo_full;
  logic          pop;

  assign km     = key_lookup(ps2_key_data);
  assign ev     = '{make: state == ST_IDLE, idx: km.idx};
  assign ev_hit = ps2_key_pressed && km.hit &&
                  (state == ST_IDLE || state == ST_BRK);
  // repeats of a held key and breaks of an idle key vanish
  assign ev_acc = ev_hit && (key_held[km.idx] != ev.make);
  assign pop    = evt.evt_valid && evt.evt_ready;

  always_ff @(posedge inclock or negedge resetn) begin
    if (!resetn) begin
      state        <= ST_IDLE;
      tmo          <= '0;
      key_held     <= '0;
      evt_overflow <= 1'b0;
    end else begin
      if (ps2_key_pressed) begin
        tmo <= '0;
        unique case (state)
          ST_IDLE: begin
            if (ps2_key_data == SC_BRK)      state <= ST_BRK;
            else if (ps2_key_data == SC_EXT) state <= ST_EXT;
          end
          ST_BRK: begin
            if (ps2_key_data == SC_BRK)      state <= ST_BRK;
            else if (ps2_key_data == SC_EXT) state <= ST_EXT;
            else                             state <= ST_IDLE;
          end
          ST_EXT: begin
            if (ps2_key_data == SC_BRK) state <= ST_EXT_BRK;
            else                        state <= ST_IDLE;
          end
          default: state <= ST_IDLE;
        endcase
      end else if (state == ST_IDLE) begin
        tmo <= '0;
      end else if (tmo == TW'(TIMEOUT_CYCLES)) begin
        state <= ST_IDLE;
        tmo   <= '0;
      end else begin
        tmo <= tmo + 1'b1;
      end

      if (ev_acc) key_held[km.idx] <= ev.make;
      if (ev_acc && fifo_full && !pop) evt_overflow <= 1'b1;
    end
  end

  ps2_evt_fifo #(
    .WIDTH (3),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .inclock   (inclock),
    .resetn    (resetn),
    .push      (ev_acc),
    .push_data (ev),
    .full      (fifo_full),
    .valid     (evt.evt_valid),
    .ready     (evt.evt_ready),
    .data      (evt.evt_code)
  );

endmodule

// File: tb/tb_ps2_key_decoder.sv
// Scoreboard bench for ps2_key_decoder: directed scan-code
// sequences with a queue-based event monitor.
module tb_ps2_key_decoder;

  localparam int TMO = 16;

  logic       inclock = 1'b0;
  logic       resetn  = 1'b0;
  logic [7:0] ps2_key_data = 8'h00;
  logic       ps2_key_pressed = 1'b0;
  logic [3:0] key_held;
  logic       evt_overflow;

  int         n_vec  = 0;
  int         n_miss = 0;
  logic [2:0] exp_q[$];

  ps2_key_decoder_if bus ();

  ps2_key_decoder #(
    .TIMEOUT_CYCLES (TMO),
    .FIFO_DEPTH     (4)
  ) dut (
    .inclock         (inclock),
    .resetn          (resetn),
    .ps2_key_data    (ps2_key_data),
    .ps2_key_pressed (ps2_key_pressed),
    .key_held        (key_held),
    .evt             (bus.master),
    .evt_overflow    (evt_overflow)
  );

  always #5 inclock = ~inclock;

  task automatic chk(input string nm, input int act,
                     input int exp);
    n_vec++;
    if (act != exp) begin
      n_miss++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // handshake seen at negedge completes on the next posedge
  always @(negedge inclock) begin
    if (resetn && bus.evt_valid && bus.evt_ready) begin
      if (exp_q.size() == 0) begin
        n_vec++;
        n_miss++;
        $display("FAIL unexpected_evt: got %0h expected none",
                 bus.evt_code);
      end else begin
        chk("evt_code", int'(bus.evt_code),
            int'(exp_q.pop_front()));
      end
    end
  end

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge inclock);
      #1;
    end
  endtask

  task automatic send(input logic [7:0] b);
    ps2_key_data    = b;
    ps2_key_pressed = 1'b1;
    @(posedge inclock);
    #1;
    ps2_key_pressed = 1'b0;
    ps2_key_data    = 8'h00;
  endtask

  task automatic do_reset();
    bus.evt_ready = 1'b0;
    resetn = 1'b0;
    exp_q.delete();
    idle(2);
    resetn = 1'b1;
    idle(1);
  endtask

  task automatic drain(input string nm);
    bus.evt_ready = 1'b1;
    for (int i = 0; i < 30; i++) begin
      if (exp_q.size() == 0) break;
      idle(1);
    end
    idle(1);
    chk({nm, "_left"}, exp_q.size(), 0);
    chk({nm, "_valid"}, int'(bus.evt_valid), 0);
    bus.evt_ready = 1'b0;
  endtask

  initial begin
    bus.evt_ready = 1'b0;
    idle(2);
    resetn = 1'b1;
    idle(1);
    chk("rst_held", int'(key_held), 0);
    chk("rst_valid", int'(bus.evt_valid), 0);
    chk("rst_code", int'(bus.evt_code), 0);
    chk("rst_ovf", int'(evt_overflow), 0);

    // single make of q
    exp_q.push_back(3'b100);
    send(8'h15);
    chk("q_held", int'(key_held), 4'b0001);
    chk("q_valid", int'(bus.evt_valid), 1);
    chk("q_code", int'(bus.evt_code), 3'b100);
    drain("q");

    // typematic repeats filtered, then break
    do_reset();
    bus.evt_ready = 1'b1;
    exp_q.push_back(3'b100);
    exp_q.push_back(3'b000);
    send(8'h15);
    send(8'h15);
    send(8'h15);
    send(8'hF0);
    send(8'h15);
    idle(2);
    chk("rep_held", int'(key_held), 0);
    drain("rep");

    // extended sequences ignored
    do_reset();
    send(8'hE0);
    send(8'h42);
    send(8'hE0);
    send(8'hF0);
    send(8'h42);
    idle(2);
    chk("ext_held", int'(key_held), 0);
    chk("ext_valid", int'(bus.evt_valid), 0);

    // stale F0 prefix abandoned after timeout
    do_reset();
    send(8'hF0);
    idle(TMO + 4);
    exp_q.push_back(3'b111);
    send(8'h42);
    chk("tmo_held", int'(key_held), 4'b1000);
    drain("tmo");

    // overflow with a full FIFO
    do_reset();
    exp_q.push_back(3'b100);
    exp_q.push_back(3'b101);
    exp_q.push_back(3'b110);
    exp_q.push_back(3'b111);
    send(8'h15);
    send(8'h35);
    send(8'h32);
    send(8'h42);
    send(8'hF0);
    send(8'h15);
    chk("ovf_flag", int'(evt_overflow), 1);
    chk("ovf_held", int'(key_held), 4'b1110);
    chk("ovf_valid", int'(bus.evt_valid), 1);
    chk("ovf_head", int'(bus.evt_code), 3'b100);
    // pop and push in the same full cycle
    exp_q.push_back(3'b100);
    bus.evt_ready = 1'b1;
    send(8'h15);
    bus.evt_ready = 1'b0;
    chk("pp_ovf", int'(evt_overflow), 1);
    chk("pp_held", int'(key_held), 4'b1111);
    chk("pp_head", int'(bus.evt_code), 3'b101);
    chk("pp_left", exp_q.size(), 4);
    drain("pp");

    // async reset in the middle of a break prefix
    do_reset();
    exp_q.push_back(3'b101);
    send(8'h35);
    send(8'hF0);
    chk("pre_held", int'(key_held), 4'b0010);
    #2;
    resetn = 1'b0;
    exp_q.delete();
    #1;
    chk("ar_held", int'(key_held), 0);
    chk("ar_valid", int'(bus.evt_valid), 0);
    chk("ar_code", int'(bus.evt_code), 0);
    chk("ar_ovf", int'(evt_overflow), 0);
    @(posedge inclock);
    #1;
    resetn = 1'b1;
    idle(1);
    exp_q.push_back(3'b100);
    send(8'h15);
    chk("ar_q_held", int'(key_held), 4'b0001);
    chk("ar_q_code", int'(bus.evt_code), 3'b100);
    drain("ar");

    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec, n_miss);
    $finish;
  end

endmodule

// File: doc/ps2_key_decoder.md
PS2_KEY_DECODER -- requirements
Module: ps2_key_decoder

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 2_500_000, meaning idle cycles after which a pending F0/E0 prefix is abandoned (50 ms at 50 MHz).
REQ-002 SHALL have parameter FIFO_DEPTH, default 4, meaning event FIFO entries (power of two, 2..16).
REQ-003 SHALL have port inclock  input  1  the system clock; single clock domain.
REQ-004 SHALL have port resetn  input  1  reset, asynchronous assertion, active-low.
REQ-005 SHALL have port ps2_key_data  input  8  received scan-code byte from the PS/2 receiver.
REQ-006 SHALL have port ps2_key_pressed  input  1  one-cycle strobe qualifying ps2_key_data.
REQ-007 SHALL have port key_held  output  4  live held state: [0]=q(0x15) [1]=y(0x35) [2]=b(0x32) [3]=k(0x42).
REQ-008 SHALL have port evt_valid  output  1  event FIFO non-empty.
REQ-009 SHALL have port evt_ready  input  1  consumer accepts the head event when high with evt_valid.
REQ-010 SHALL have port evt_code  output  3  head event: [1:0]=key index per REQ-007, [2]=1 make / 0 break.
REQ-011 SHALL have port evt_overflow  output  1  sticky flag; an event was dropped.

Function
REQ-012 SHALL run a parser FSM with states IDLE, BRK, EXT, EXT_BRK, advancing only on cycles where ps2_key_pressed=1.
REQ-013 IDLE: 0xF0->BRK; 0xE0->EXT; a mapped code->make event, stay IDLE; any other byte (incl. 0xAA, 0xFA, 0xEE)->ignored, stay IDLE.
REQ-014 BRK: a mapped code->break event, ->IDLE; 0xF0->stay BRK; 0xE0->EXT; any other byte->IDLE, no event.
REQ-015 EXT: 0xF0->EXT_BRK; any other byte->IDLE, no event (extended keys unmapped).
REQ-016 EXT_BRK: any byte->IDLE, no event.
REQ-017 Timeout counter SHALL clear on every strobe and in IDLE; on reaching TIMEOUT_CYCLES in a non-IDLE state, FSM SHALL go to IDLE.
REQ-018 A make event for a key already held SHALL update nothing and enqueue nothing (typematic repeat filter).
REQ-019 A break event for a key not held SHALL be dropped silently, without setting evt_overflow.
REQ-020 An accepted make/break SHALL set/clear the key_held bit on the clock edge following the strobe cycle (latency 1).
REQ-021 The same accepted event SHALL be pushed into the FIFO on the same edge; evt_valid SHALL rise on that edge if the FIFO was empty.
REQ-022 The FIFO SHALL pop on evt_valid && evt_ready; evt_code SHALL stay stable while evt_valid && !evt_ready.
REQ-023 A push SHALL be accepted when the FIFO is not full, or when it is full and a pop occurs in the same cycle.
REQ-024 Otherwise the push SHALL be dropped and evt_overflow set; key_held SHALL still update.
REQ-025 With the FIFO empty, a simultaneous push and ready SHALL NOT bypass: the event appears on evt_valid the next cycle.
REQ-026 FIFO pointers SHALL wrap modulo FIFO_DEPTH; the occupancy counter SHALL be log2(FIFO_DEPTH)+1 bits.

Reset
REQ-027 resetn low SHALL asynchronously force: FSM=IDLE, timeout=0, key_held=0, FIFO empty, evt_valid=0, evt_code=0, evt_overflow=0.
REQ-028 Reset mid-sequence (e.g. after 0xF0) SHALL discard the pending prefix; the next byte is parsed from IDLE.
REQ-029 Deassertion SHALL be consumed synchronously; the first strobe after release SHALL be parsed normally.

Structure
REQ-030 A shared package SHALL hold the scan-code constants (0xF0, 0xE0, 0x15, 0x35, 0x32, 0x42), the key-index encodings and the parser state encoding.
REQ-031 The event FIFO SHALL be one sub-module, ps2_evt_fifo (parameterised width/depth, valid/ready read side, push/full write side); the parser and held-key register stay in the top.

Verification
REQ-032 Bytes 0x15 -> key_held=0001 one cycle later; evt_code=3'b100, evt_valid=1.
REQ-033 Bytes 0x15,0x15,0x15 then 0xF0,0x15 with evt_ready=1 -> exactly two events, 3'b100 then 3'b000; key_held returns to 0000.
REQ-034 Bytes 0xE0,0x42 then 0xE0,0xF0,0x42 -> no events; key_held=0000.
REQ-035 Byte 0xF0, then TIMEOUT_CYCLES idle, then 0x42 -> make event 3'b111 (not a break); key_held[3]=1.
REQ-036 evt_ready=0; make q,y,b,k, then break q (5 events, FIFO_DEPTH=4) -> 4 events queued, evt_overflow=1, key_held=1110; a pop and push in the same full cycle leaves 4 entries and evt_overflow unchanged.
REQ-037 Byte 0xF0, resetn pulsed low mid-cycle, then 0x15 -> immediate async clear of all outputs; a make event for q follows.
